mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the 5-stage ARM-subset pipeline; the producing end of the register-file writeback port that the decode stage consumes.
- Accepts one EXE-stage result per cycle and issues loads/stores to a variable-latency data memory over a req/ack handshake.
- Stalls upstream while a memory access is outstanding.
- Drives a registered, single-cycle writeback (enable, value, destination) to the decode stage's register file.

Parameters:
- DATA_W, 32, data/address width.
- REG_W, 4, register index width.
- ADDR_BASE, 1024, byte offset subtracted from the ALU result to form the memory address.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EXE result present this cycle.
- in_wb_en  in  1  instruction writes a register.
- in_mem_r  in  1  load.
- in_mem_w  in  1  store.
- in_alu_res  in  DATA_W  ALU result (address for memory ops, value otherwise).
- in_st_val  in  DATA_W  store data (Rm value).
- in_dest  in  REG_W  destination register.
- stall  out  1  upstream must hold in_* stable and not advance.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  DATA_W  in_alu_res − ADDR_BASE, latched.
- mem_wdata  out  DATA_W  latched store data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- WB_WB_EN  out  1  register-file write enable.
- WB_Value  out  DATA_W  write data.
- WB_Dest  out  REG_W  write index.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - stall, mem_req, mem_we, WB_WB_EN = 0.
  - mem_addr, mem_wdata, WB_Value, WB_Dest = 0.
  - A reset during MEM_WAIT abandons the access: mem_req drops immediately and no writeback occurs.
- FSM states: IDLE, MEM_WAIT.
- stall = (state == MEM_WAIT). Combinational from state only; high in the ack cycle too.
- IDLE, in_valid=1, in_mem_r|in_mem_w=1:
  - Latch mem_addr = in_alu_res − ADDR_BASE (modulo 2^DATA_W), mem_wdata = in_st_val, dest, wb_en.
  - mem_we = in_mem_w & ~in_mem_r. Read wins if both are set (illegal encoding, defined for robustness).
  - Assert mem_req next cycle; go to MEM_WAIT.
- IDLE, in_valid=1, no memory op:
  - Next cycle WB_WB_EN = in_wb_en, WB_Value = in_alu_res, WB_Dest = in_dest. Latency 1.
- IDLE, in_valid=0: WB_WB_EN = 0 next cycle.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack.
  - On mem_ack (cycle t): mem_req = 0 and state = IDLE at t+1.
  - Load: WB_WB_EN = latched wb_en, WB_Value = mem_rdata sampled at t, WB_Dest = latched dest, all at t+1.
  - Store: WB_WB_EN = 0.
- mem_ack in IDLE is ignored.
- Zero-wait memory (ack in the first MEM_WAIT cycle) is legal: 2-cycle occupancy.
- in_* is sampled only in IDLE; in MEM_WAIT inputs are ignored (upstream is holding them).
- The instruction held during MEM_WAIT is accepted in the first IDLE cycle after ack.
- WB_WB_EN is a one-cycle pulse per writeback.
- WB_Value and WB_Dest hold their last value while WB_WB_EN = 0.
- Back-to-back non-memory instructions produce one writeback per cycle, no bubbles.

Decomposition:
- Shared pipeline package holds:
  - ADDR_BASE constant.
  - State enum {IDLE, MEM_WAIT}.
  - REG_W/DATA_W defaults, reused by the decode stage and register file.
- One natural sub-module: wb_reg, the registered WB_WB_EN/WB_Value/WB_Dest output stage with hold-on-disable. FSM and memory latch stay in the top.

Test Plan:
- ALU op: in_valid=1, wb_en=1, alu_res=0x0000002A, dest=3 → next cycle WB_WB_EN=1, WB_Value=0x2A, WB_Dest=3; the cycle after, WB_WB_EN=0 and value/dest hold.
- Load with 3-cycle memory: alu_res=1028, mem_r=1, dest=5 → mem_req=1, mem_we=0, mem_addr=4 until ack; ack with rdata=0xDEADBEEF → next cycle WB_WB_EN=1, WB_Value=0xDEADBEEF, WB_Dest=5; stall high from the cycle after accept through the ack cycle.
- Store: alu_res=1032, st_val=0x12345678, mem_w=1 → mem_we=1, mem_addr=8, mem_wdata=0x12345678 held until ack; no WB_WB_EN pulse.
- Zero-wait load followed by an ALU op held under stall: ack in the first MEM_WAIT cycle → load writeback, then the ALU writeback on the next consecutive cycle.
- Reset asserted mid-MEM_WAIT → mem_req=0, stall=0, all WB outputs 0 immediately; after release, a stray mem_ack is ignored.
- Spurious mem_ack while IDLE with in_valid=0 → no state change, WB_WB_EN stays 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the memory/writeback stage, decode stage and register file.
package mem_wb_stage_pkg;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 4;
  localparam int ADDR_BASE = 1024;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = mem_wb_stage_pkg::DATA_W
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage_wb_reg.sv
// Registered writeback port: enable is a one-cycle pulse, value/dest hold while enable is low.
module mem_wb_stage_wb_reg #(
  parameter int DATA_W = mem_wb_stage_pkg::DATA_W,
  parameter int REG_W  = mem_wb_stage_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_d,
  input  logic [DATA_W-1:0] wb_value_d,
  input  logic [REG_W-1:0]  wb_dest_d,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_value,
  output logic [REG_W-1:0]  wb_dest
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      wb_value <= '0;
      wb_dest  <= '0;
    end else begin
      wb_en <= wb_en_d;
      if (wb_en_d) begin
        wb_value <= wb_value_d;
        wb_dest  <= wb_dest_d;
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues loads/stores over req/ack, stalls upstream while waiting.
//   state    | meaning
//   IDLE     | accepting one EXE result per cycle; ALU results written back next cycle
//   MEM_WAIT | memory access outstanding; stall high, request held until mem_ack
module mem_wb_stage #(
  parameter int DATA_W    = mem_wb_stage_pkg::DATA_W,
  parameter int REG_W     = mem_wb_stage_pkg::REG_W,
  parameter int ADDR_BASE = mem_wb_stage_pkg::ADDR_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_wb_en,
  input  logic              in_mem_r,
  input  logic              in_mem_w,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [REG_W-1:0]  in_dest,
  output logic              stall,
  mem_wb_stage_if.master    mem,
  output logic              WB_WB_EN,
  output logic [DATA_W-1:0] WB_Value,
  output logic [REG_W-1:0]  WB_Dest
);
  import mem_wb_stage_pkg::*;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_we_q, lat_wb_en;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic [REG_W-1:0]  lat_dest;
  logic              wb_en_d;
  logic [DATA_W-1:0] wb_value_d;
  logic [REG_W-1:0]  wb_dest_d;
  logic              is_mem, accept_mem;

  assign is_mem     = in_mem_r | in_mem_w;
  assign accept_mem = (state_q == IDLE) && in_valid && is_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_mem) state_d = MEM_WAIT;
      MEM_WAIT: if (mem.mem_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = (state_q == MEM_WAIT);
    wb_en_d    = 1'b0;
    wb_value_d = in_alu_res;
    wb_dest_d  = in_dest;
    case (state_q)
      IDLE: begin
        if (in_valid && !is_mem) wb_en_d = in_wb_en;
      end
      MEM_WAIT: begin
        // Only loads write back; stores complete silently.
        if (mem.mem_ack && !mem_we_q) begin
          wb_en_d    = lat_wb_en;
          wb_value_d = mem.mem_rdata;
          wb_dest_d  = lat_dest;
        end
      end
      default: wb_en_d = 1'b0;
    endcase
  end

  // Request latch: captured on accept, held stable until ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_dest    <= '0;
      lat_wb_en   <= 1'b0;
    end else if (accept_mem) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= in_mem_w & ~in_mem_r;
      mem_addr_q  <= in_alu_res - DATA_W'(ADDR_BASE);
      mem_wdata_q <= in_st_val;
      lat_dest    <= in_dest;
      lat_wb_en   <= in_wb_en;
    end else if ((state_q == MEM_WAIT) && mem.mem_ack) begin
      mem_req_q   <= 1'b0;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  mem_wb_stage_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .wb_en_d    (wb_en_d),
    .wb_value_d (wb_value_d),
    .wb_dest_d  (wb_dest_d),
    .wb_en      (WB_WB_EN),
    .wb_value   (WB_Value),
    .wb_dest    (WB_Dest)
  );

endmodule
